// File: rtl/riscv_pipe_stage.sv
// Inter-stage pipeline register with valid/ready handshake, flush and optional 2-entry skid buffer.
// Control bits are gated by out_valid so an empty slot always presents a NOP downstream.
module riscv_pipe_stage #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    logic              m_vld_q, m_vld_d;
    logic              s_vld_q, s_vld_d;
    logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
    logic              rdy_q, rdy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, emit;

    // Without the skid entry, ready depends combinationally on out_ready; flush keeps it high.
    assign in_ready = (SKID != 0) ? rdy_q : (~m_vld_q | out_ready | flush);
    assign accept   = in_valid & in_ready;
    assign emit     = m_vld_q & out_ready;

    always_comb begin
        m_vld_d  = m_vld_q;
        s_vld_d  = s_vld_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
        if (flush) begin
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (SKID != 0) begin
            if (s_vld_q) begin
                if (emit) begin
                    m_data_d = s_data_q;
                    m_ctrl_d = s_ctrl_q;
                    s_vld_d  = 1'b0;
                end
            end else if (m_vld_q) begin
                if (accept && emit) begin
                    m_data_d = in_data;
                    m_ctrl_d = in_ctrl;
                end else if (accept) begin
                    s_data_d = in_data;
                    s_ctrl_d = in_ctrl;
                    s_vld_d  = 1'b1;
                end else if (emit) begin
                    m_vld_d = 1'b0;
                end
            end else if (accept) begin
                m_data_d = in_data;
                m_ctrl_d = in_ctrl;
                m_vld_d  = 1'b1;
            end
        end else begin
            if (accept) begin
                m_data_d = in_data;
                m_ctrl_d = in_ctrl;
                m_vld_d  = 1'b1;
            end else if (emit) begin
                m_vld_d = 1'b0;
            end
        end
        rdy_d = ~s_vld_d;
        cnt_d = (m_vld_q & ~out_ready) ? sat_inc(cnt_q) : cnt_q;
    end

    // Stage register boundary: main/skid entries, registered ready, stall counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_vld_q  <= 1'b0;
            s_vld_q  <= 1'b0;
            m_data_q <= '0;
            m_ctrl_q <= '0;
            s_data_q <= '0;
            s_ctrl_q <= '0;
            rdy_q    <= 1'b1;
            cnt_q    <= '0;
        end else begin
            m_vld_q  <= m_vld_d;
            s_vld_q  <= s_vld_d;
            m_data_q <= m_data_d;
            m_ctrl_q <= m_ctrl_d;
            s_data_q <= s_data_d;
            s_ctrl_q <= s_ctrl_d;
            rdy_q    <= rdy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = m_vld_q;
    assign out_data  = m_data_q;
    assign out_ctrl  = m_vld_q ? m_ctrl_q : '0;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_pipe_stage.sv
// Bench for riscv_pipe_stage: skid (SKID=1, 4-bit counter) and combinational-ready (SKID=0) instances
// driven with directed and random traffic, checked against a FIFO-occupancy reference model.
module tb_riscv_pipe_stage;

    localparam int DW = 16;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          iv, fl, ordy;
    logic [DW-1:0] id;
    logic [CW-1:0] ic;

    logic          a_ir, a_ov;
    logic [DW-1:0] a_od;
    logic [CW-1:0] a_oc;
    logic [3:0]    a_cnt;

    logic          b_ir, b_ov;
    logic [DW-1:0] b_od;
    logic [CW-1:0] b_oc;
    logic [15:0]   b_cnt;

    riscv_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_skid (
        .CLK(clk), .RESET(rst), .in_valid(iv), .in_ready(a_ir), .in_data(id), .in_ctrl(ic),
        .flush(fl), .out_valid(a_ov), .out_ready(ordy), .out_data(a_od), .out_ctrl(a_oc),
        .stall_cnt(a_cnt)
    );

    riscv_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_comb (
        .CLK(clk), .RESET(rst), .in_valid(iv), .in_ready(b_ir), .in_data(id), .in_ctrl(ic),
        .flush(fl), .out_valid(b_ov), .out_ready(ordy), .out_data(b_od), .out_ctrl(b_oc),
        .stall_cnt(b_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t mq[$];
    bit   m_ir;
    int   m_cnt;
    int   cnt_max;
    int   sel;
    int   checks   = 0;
    int   failures = 0;
    int   n_acc, n_emit;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ir  = 1'b1;
        m_cnt = 0;
    endtask

    // One clock cycle: drive at negedge, check outputs, advance the model at posedge.
    task automatic cyc(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit f, input bit r);
        bit            ov, ir, exp_ov, exp_ir, acc, emi;
        logic [DW-1:0] od;
        logic [CW-1:0] oc;
        int            cn;
        ent_t          e;
        iv = v; id = d; ic = c; fl = f; ordy = r;
        #1;
        if (sel == 0) begin
            ov = a_ov; ir = a_ir; od = a_od; oc = a_oc; cn = int'(a_cnt);
        end else begin
            ov = b_ov; ir = b_ir; od = b_od; oc = b_oc; cn = int'(b_cnt);
        end
        exp_ov = (mq.size() > 0);
        exp_ir = (sel == 0) ? m_ir : (!exp_ov || r || f);
        check_eq("out_valid", 64'(ov), 64'(exp_ov));
        check_eq("in_ready", 64'(ir), 64'(exp_ir));
        check_eq("out_ctrl", 64'(oc), exp_ov ? 64'(mq[0].c) : 64'(0));
        if (exp_ov) check_eq("out_data", 64'(od), 64'(mq[0].d));
        check_eq("stall_cnt", 64'(cn), 64'(m_cnt));
        acc = v && exp_ir;
        emi = exp_ov && r;
        if (acc) n_acc++;
        if (ov && r) n_emit++;
        @(posedge clk);
        if (exp_ov && !r && m_cnt < cnt_max) m_cnt++;
        if (emi) void'(mq.pop_front());
        if (f) begin
            mq.delete();
        end else if (acc) begin
            e.d = d;
            e.c = c;
            mq.push_back(e);
        end
        if (sel == 0) m_ir = (mq.size() < 2);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; iv = 1'b0; id = '0; ic = '0; fl = 1'b0; ordy = 1'b0;
        sel = 0; cnt_max = 15; n_acc = 0; n_emit = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_a_valid", 64'(a_ov), 64'(0));
        check_eq("rst_a_data", 64'(a_od), 64'(0));
        check_eq("rst_a_ctrl", 64'(a_oc), 64'(0));
        check_eq("rst_a_cnt", 64'(a_cnt), 64'(0));
        check_eq("rst_a_ready", 64'(a_ir), 64'(1));
        check_eq("rst_b_valid", 64'(b_ov), 64'(0));
        check_eq("rst_b_ready", 64'(b_ir), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        // Streaming through the skid instance
        for (int i = 0; i < 8; i++) cyc(1'b1, DW'(16'h10 + i), 8'h01, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Stall fills skid entry, then drain
        cyc(1'b1, 16'hA0, 8'hFF, 1'b0, 1'b0);
        cyc(1'b1, 16'hA1, 8'hFF, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
        check_eq("stall_full_ready", 64'(a_ir), 64'(0));
        check_eq("stall_cnt3", 64'(a_cnt), 64'(3));
        check_eq("stall_hold_data", 64'(a_od), 64'(16'hA0));
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Flush while full with a competing input word
        cyc(1'b1, 16'hC0, 8'hFF, 1'b0, 1'b0);
        cyc(1'b1, 16'hC1, 8'hFF, 1'b0, 1'b0);
        cyc(1'b1, 16'hBB, 8'hFF, 1'b1, 1'b1);
        cyc(1'b1, 16'hBB, 8'hFF, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Saturating stall counter
        cyc(1'b1, 16'h77, 8'h05, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
        check_eq("cnt_sat", 64'(a_cnt), 64'(15));
        cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Asynchronous reset while full
        cyc(1'b1, 16'hD0, 8'h3C, 1'b0, 1'b0);
        cyc(1'b1, 16'hD1, 8'h3C, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("areset_valid", 64'(a_ov), 64'(0));
        check_eq("areset_data", 64'(a_od), 64'(0));
        check_eq("areset_ctrl", 64'(a_oc), 64'(0));
        check_eq("areset_cnt", 64'(a_cnt), 64'(0));
        check_eq("areset_ready", 64'(a_ir), 64'(1));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 16'h55, 8'h11, 1'b0, 1'b1);
        check_eq("post_reset_data", 64'(a_od), 64'(16'h55));
        cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Random traffic with occasional flush on the skid instance
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));

        // Combinational-ready instance
        sel = 1;
        cnt_max = 65535;
        @(negedge clk);
        pulse_reset();
        cyc(1'b1, 16'h20, 8'h02, 1'b0, 1'b1);
        cyc(1'b1, 16'h21, 8'h02, 1'b0, 1'b1);
        cyc(1'b1, 16'h22, 8'h02, 1'b0, 1'b0);
        cyc(1'b1, 16'h23, 8'h02, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);

        n_acc = 0;
        n_emit = 0;
        for (int i = 0; i < 3000 && n_acc < 100; i++)
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 1'b0,
                ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
        check_eq("sb_sent", 64'(n_acc), 64'(100));
        check_eq("sb_drained", 64'(n_emit), 64'(n_acc));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
